// File: rtl/sum_uart_pkg.sv
// Shared types and widths for the sum UART transmitter.
// The state enum is used by the FSM in sum_uart_tx.
package sum_uart_pkg;

    localparam int DATA_W = 8;
    localparam int DIV_W  = 12;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } uart_state_t;

endpackage

// File: rtl/sum_uart_tx_baud_timer.sv
// Bit-time down-counter: reloads div-1 on load, saturates at zero.
// tick marks the last cycle of the current bit time.
module baud_timer
    import sum_uart_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [DIV_W-1:0] div,
    output logic             tick
);

    logic [DIV_W-1:0] count;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= div - 1'b1;
        end else if (count != '0) begin
            count <= count - 1'b1;
        end
    end

    assign tick = (count == '0);

endmodule

// File: rtl/sum_uart_tx.sv
// One-byte buffered UART transmitter (8N1, optional 8E1) for the adder sum.
// tx is registered and computed from the next state, so it never glitches.
module sum_uart_tx
    import sum_uart_pkg::*;
#(
    parameter int CLK_DIV   = 87,
    parameter bit PARITY_EN = 1'b0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              tx,
    output logic              busy
);

    uart_state_t       state, state_next;
    logic [DATA_W-1:0] hold_data;
    logic              hold_valid;
    logic              take_hold;
    logic [DATA_W-1:0] shift, shift_next;
    logic [2:0]        bit_idx, bit_idx_next;
    logic              parity, parity_next;
    logic              tx_next;
    logic              timer_load;
    logic              bit_tick;

    baud_timer u_baud_timer (
        .clk  (clk),
        .rst  (rst),
        .load (timer_load),
        .div  (DIV_W'(CLK_DIV)),
        .tick (bit_tick)
    );

    assign in_ready = !hold_valid && !rst;
    assign busy     = (state != IDLE) || hold_valid;

    always_ff @(posedge clk) begin
        if (rst) begin
            hold_valid <= 1'b0;
        end else if (in_valid && in_ready) begin
            hold_valid <= 1'b1;
        end else if (take_hold) begin
            hold_valid <= 1'b0;
        end
    end

    // NOTE: the data register has no reset; its contents only matter while hold_valid is set.
    always_ff @(posedge clk) begin
        if (in_valid && in_ready) begin
            hold_data <= in_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            tx      <= 1'b1;
            shift   <= '0;
            bit_idx <= '0;
            parity  <= 1'b0;
        end else begin
            state   <= state_next;
            tx      <= tx_next;
            shift   <= shift_next;
            bit_idx <= bit_idx_next;
            parity  <= parity_next;
        end
    end

    // NOTE: every output of this block is defaulted first so no path can infer a latch.
    always_comb begin
        state_next   = state;
        shift_next   = shift;
        bit_idx_next = bit_idx;
        parity_next  = parity;
        tx_next      = tx;
        timer_load   = 1'b0;
        take_hold    = 1'b0;

        unique case (state)
            IDLE: begin
                tx_next = 1'b1;
                if (hold_valid) begin
                    state_next  = START;
                    shift_next  = hold_data;
                    parity_next = ^hold_data;
                    tx_next     = 1'b0;
                    timer_load  = 1'b1;
                    take_hold   = 1'b1;
                end
            end
            START: begin
                if (bit_tick) begin
                    state_next   = DATA;
                    bit_idx_next = '0;
                    tx_next      = shift[0];
                    timer_load   = 1'b1;
                end
            end
            DATA: begin
                if (bit_tick) begin
                    shift_next = shift >> 1;
                    timer_load = 1'b1;
                    if (bit_idx == 3'd7) begin
                        if (PARITY_EN) begin
                            state_next = PARITY;
                            tx_next    = parity;
                        end else begin
                            state_next = STOP;
                            tx_next    = 1'b1;
                        end
                    end else begin
                        bit_idx_next = bit_idx + 3'd1;
                        tx_next      = shift[1];
                    end
                end
            end
            PARITY: begin
                if (bit_tick) begin
                    state_next = STOP;
                    tx_next    = 1'b1;
                    timer_load = 1'b1;
                end
            end
            STOP: begin
                if (bit_tick) begin
                    if (hold_valid) begin
                        // Chain straight into the next start bit with no idle cycle.
                        state_next  = START;
                        shift_next  = hold_data;
                        parity_next = ^hold_data;
                        tx_next     = 1'b0;
                        timer_load  = 1'b1;
                        take_hold   = 1'b1;
                    end else begin
                        state_next = IDLE;
                        tx_next    = 1'b1;
                    end
                end
            end
            default: begin
                state_next = IDLE;
                tx_next    = 1'b1;
            end
        endcase
    end

endmodule

// File: tb/tb_sum_uart_tx.sv
// Self-checking bench: directed frame timing checks plus a random scoreboard
// run, on one 8N1 and one 8E1 instance, both with CLK_DIV = 4.
module tb_sum_uart_tx;

    localparam int DIV = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] in_data0 = '0, in_data1 = '0;
    logic       in_valid0 = 1'b0, in_valid1 = 1'b0;
    logic       in_ready0, in_ready1;
    logic       tx0, tx1;
    logic       busy0, busy1;

    int n_cmp = 0;
    int n_bad = 0;

    logic [7:0] acc0[$];
    logic [7:0] acc1[$];
    int         rx_cnt[2] = '{0, 0};
    int         pos[2]    = '{-1, -1};
    logic [10:0] fb[2];

    always #5 clk = ~clk;

    sum_uart_tx #(.CLK_DIV(DIV), .PARITY_EN(1'b0)) dut0 (
        .clk(clk), .rst(rst), .in_data(in_data0), .in_valid(in_valid0),
        .in_ready(in_ready0), .tx(tx0), .busy(busy0)
    );

    sum_uart_tx #(.CLK_DIV(DIV), .PARITY_EN(1'b1)) dut1 (
        .clk(clk), .rst(rst), .in_data(in_data1), .in_valid(in_valid1),
        .in_ready(in_ready1), .tx(tx1), .busy(busy1)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Expected line level for bit slot b of a frame carrying d.
    function automatic logic frame_bit(input logic [7:0] d, input bit par, input int b);
        if (b == 0) return 1'b0;
        if (b <= 8) return d[b-1];
        if (par && b == 9) return ^d;
        return 1'b1;
    endfunction

    // Handshake monitor: a byte is taken on the next edge when valid && ready.
    always @(negedge clk) begin
        if (in_valid0 && in_ready0) acc0.push_back(in_data0);
        if (in_valid1 && in_ready1) acc1.push_back(in_data1);
    end

    // Line receiver: samples each bit slot mid-bit and scoreboards complete frames.
    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            logic       txi;
            int         nb;
            logic [7:0] d;
            txi = (i == 0) ? tx0 : tx1;
            nb  = (i == 0) ? 10 : 11;
            if (rst) begin
                pos[i] = -1;
            end else begin
                if (pos[i] < 0 && txi == 1'b0) pos[i] = 0;
                if (pos[i] >= 0) begin
                    if (pos[i] % DIV == DIV / 2) fb[i][pos[i] / DIV] = txi;
                    if (pos[i] == nb * DIV - 1) begin
                        d = fb[i][8:1];
                        check("rx_start", fb[i][0], 1'b0);
                        check("rx_stop", fb[i][nb-1], 1'b1);
                        if (i == 1) check("rx_parity", fb[i][9], ^d);
                        if (i == 0) begin
                            check("rx_expected0", acc0.size() > 0, 1'b1);
                            if (acc0.size() > 0) check("rx_data0", d, acc0.pop_front());
                        end else begin
                            check("rx_expected1", acc1.size() > 0, 1'b1);
                            if (acc1.size() > 0) check("rx_data1", d, acc1.pop_front());
                        end
                        rx_cnt[i]++;
                        pos[i] = -1;
                    end else begin
                        pos[i]++;
                    end
                end
            end
        end
    end

    // Offers d on instance inst; returns 1 ns after the accepting edge.
    task automatic send(input int inst, input logic [7:0] d);
        bit got = 0;
        @(posedge clk); #1;
        if (inst == 0) begin in_valid0 = 1'b1; in_data0 = d; end
        else           begin in_valid1 = 1'b1; in_data1 = d; end
        for (int t = 0; t < 500; t++) begin
            @(negedge clk);
            if ((inst == 0) ? in_ready0 : in_ready1) begin got = 1; break; end
        end
        check("send_accepted", got, 1'b1);
        @(posedge clk); #1;
        if (inst == 0) in_valid0 = 1'b0; else in_valid1 = 1'b0;
    endtask

    task automatic wait_idle(input int inst);
        logic b = 1'b1;
        for (int t = 0; t < 3000; t++) begin
            @(negedge clk);
            b = (inst == 0) ? busy0 : busy1;
            if (!b) break;
        end
        check("idle_reached", b, 1'b0);
    endtask

    // Sends one byte from idle and checks the line cycle by cycle.
    task automatic frame_test(input int inst, input logic [7:0] d);
        int nb = (inst == 0) ? 10 : 11;
        send(inst, d);
        @(negedge clk);
        check("pre_start_tx", (inst == 0) ? tx0 : tx1, 1'b1);
        check("pre_start_busy", (inst == 0) ? busy0 : busy1, 1'b1);
        check("pre_start_ready", (inst == 0) ? in_ready0 : in_ready1, 1'b0);
        for (int c = 0; c < nb * DIV; c++) begin
            @(negedge clk);
            check($sformatf("frame_%0h_c%0d", d, c), (inst == 0) ? tx0 : tx1,
                  frame_bit(d, inst == 1, c / DIV));
            if (c == nb * DIV - 1) check("busy_last_stop", (inst == 0) ? busy0 : busy1, 1'b1);
        end
        @(negedge clk);
        check("busy_after_frame", (inst == 0) ? busy0 : busy1, 1'b0);
        check("tx_after_frame", (inst == 0) ? tx0 : tx1, 1'b1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        int hs;
        int bad;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_tx0", tx0, 1'b1);
        check("rst_tx1", tx1, 1'b1);
        check("rst_busy0", busy0, 1'b0);
        check("rst_ready0", in_ready0, 1'b0);
        check("rst_ready1", in_ready1, 1'b0);
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        check("ready_after_rst", in_ready0, 1'b1);

        // Single 8N1 frame and two 8E1 frames
        frame_test(0, 8'hA5);
        frame_test(1, 8'h07);
        frame_test(1, 8'h03);

        // Back-to-back: 0x00 then 0xFF, third byte 0x3C held off
        @(posedge clk); #1;
        in_valid0 = 1'b1; in_data0 = 8'h00;
        @(negedge clk);
        check("b2b_ready_idle", in_ready0, 1'b1);
        @(posedge clk); #1 in_data0 = 8'hFF;
        @(negedge clk);
        check("b2b_ready_after_acc", in_ready0, 1'b0);
        for (int c = 0; c < 20 * DIV; c++) begin
            @(posedge clk); #1;
            if (c == 1) in_data0 = 8'h3C;
            if (c == 41) in_valid0 = 1'b0;
            @(negedge clk);
            check($sformatf("b2b_tx_c%0d", c), tx0,
                  (c < 10 * DIV) ? frame_bit(8'h00, 0, c / DIV) : frame_bit(8'hFF, 0, c / DIV - 10));
            if (c == 0 || c == 10 * DIV) check($sformatf("b2b_ready_c%0d", c), in_ready0, 1'b1);
            else if (c < 10 * DIV) check($sformatf("b2b_stall_c%0d", c), in_ready0, 1'b0);
        end
        wait_idle(0);
        check("b2b_frames", rx_cnt[0], 4);

        // Reset during data bit 3 of 0x5A with 0x11 buffered
        send(0, 8'h5A);
        send(0, 8'h11);
        repeat (16) @(posedge clk);
        #1 rst = 1'b1;
        acc0.delete();
        base = rx_cnt[0];
        @(negedge clk);
        check("midrst_ready_low", in_ready0, 1'b0);
        @(negedge clk);
        check("midrst_tx", tx0, 1'b1);
        check("midrst_busy", busy0, 1'b0);
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        check("midrst_ready_release", in_ready0, 1'b1);
        bad = 0;
        for (int t = 0; t < 100; t++) begin
            @(negedge clk);
            if (tx0 !== 1'b1) bad++;
        end
        check("midrst_line_quiet", bad, 0);
        check("midrst_no_frames", rx_cnt[0] - base, 0);

        // Producer stall: in_valid held, exactly three handshakes -> three frames
        base = rx_cnt[0];
        hs = 0;
        @(posedge clk); #1;
        in_valid0 = 1'b1; in_data0 = 8'hC3;
        for (int t = 0; t < 400 && hs < 3; t++) begin
            @(negedge clk);
            if (in_ready0) hs++;
            if (hs < 3) begin @(posedge clk); #1; end
        end
        check("stall_handshakes", hs, 3);
        @(posedge clk); #1 in_valid0 = 1'b0;
        wait_idle(0);
        check("stall_frames", rx_cnt[0] - base, 3);

        // Random traffic on both instances, scoreboarded by the receiver
        for (int n = 0; n < 24; n++) begin
            send($urandom_range(0, 1), 8'($urandom));
            repeat ($urandom_range(0, 60)) @(posedge clk);
        end
        wait_idle(0);
        wait_idle(1);
        check("drain0", acc0.size(), 0);
        check("drain1", acc1.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/sum_uart_tx.md
# sum_uart_tx

Downstream serial stage for the byte produced by the top-level operand adder. It accepts each 8-bit sum over a valid/ready handshake, buffers one byte, and transmits it LSB-first as a standard 8N1 (optionally 8E1) UART frame on a single output pin. This lets an external host log results without sampling the parallel `uo_out` bus. It is instantiated inside the top module and drives one `uio_out` bit, with the matching `uio_oe` bit set to 1.

## Interface
- `CLK_DIV`, default 87: clock cycles per bit time. For example, 10 MHz / 115200 baud. Legal range is 2..4095.
- `PARITY_EN`, default 0: 1 inserts an even-parity bit between the data bits and the stop bit.
- `clk` input, 1 bit: the only clock. All state changes on its rising edge.
- `rst` input, 1 bit: synchronous, active-high reset. The top level drives it from `~rst_n`.
- `in_data` input, 8 bits: the byte to send. Normally this is the adder sum.
- `in_valid` input, 1 bit: `in_data` is valid this cycle.
- `in_ready` output, 1 bit: the block can accept a byte this cycle.
- `tx` output, 1 bit: the serial line. It idles high.
- `busy` output, 1 bit: a frame is in flight or a byte is buffered.

## Operation
- **Handshake.** A byte is accepted on the rising edge where `in_valid && in_ready`.
  - `in_ready = !hold_valid && !rst`.
  - The producer must hold `in_data` stable while `in_valid` is high and `in_ready` is low.
- **Holding register.** It holds one byte. Acceptance sets `hold_valid`. The FSM clears it in the cycle it loads the byte.
- **FSM states:** IDLE, START, DATA, PARITY, STOP.
  - IDLE: if `hold_valid`, go to START. Load the shift register from hold and clear `hold_valid`.
  - START: drive `tx` = 0 for one bit time, then go to DATA with `bit_idx` = 0.
  - DATA: drive `tx` = `shift[0]` for one bit time, then shift right and increment `bit_idx`.
    - After bit 7, go to PARITY if `PARITY_EN`, otherwise go to STOP.
  - PARITY: drive `tx` = XOR of the 8 data bits (even parity) for one bit time, then go to STOP.
  - STOP: drive `tx` = 1 for one bit time.
    - At the end of the bit time, if `hold_valid`, go directly to START and load the next byte. There is no idle gap.
    - Otherwise go to IDLE.
- **Bit timer.** It loads `CLK_DIV-1` on entry to every state except IDLE and decrements each cycle. The bit time ends on the cycle where the timer is 0.
  - Counter width is 12 bits.
  - There is no wrap-around: the timer never counts below 0.
- **Output register.** `tx` is registered and is a direct function of the state and shift register. No glitches are permitted.
- **Busy.** `busy = (state != IDLE) || hold_valid`.
- **Reset values:** state = IDLE, `tx` = 1, `hold_valid` = 0, `busy` = 0, `in_ready` = 0 while `rst` is high.
- **Reset mid-frame.** The current frame and any buffered byte are dropped. `tx` is 1 from the first edge where `rst` is sampled high. No partial stop bit is emitted.

## Timing
- **Acceptance to start bit.** A byte accepted at edge k gives `hold_valid` = 1 after edge k. If IDLE, `tx` falls after edge k+1, which is 1 cycle of latency.
- **Frame length.** Exactly `10*CLK_DIV` cycles, or `11*CLK_DIV` cycles with parity.
- **in_ready after acceptance.** It is low for the cycle after acceptance. It is high again after the FSM loads the byte, which is edge k+1 when IDLE.
  - A second byte can therefore be buffered during the first frame.
  - A third byte stalls until the second byte is loaded.
- **Accept and load in the same cycle** cannot occur: `in_ready` is low whenever `hold_valid` is high.
- **Back-to-back frames.** The second start bit begins on the cycle immediately after the last stop-bit cycle.

## Structure
- **Package `sum_uart_pkg`:** the state enum `uart_state_t` (IDLE, START, DATA, PARITY, STOP), `DATA_W` = 8, and `DIV_W` = 12.
- **Sub-module `baud_timer`:**
  - Inputs: `load` and `div`.
  - Outputs: `tick`, asserted when the count is 0.
  - Used by the FSM for all bit-time decisions.
- The FSM, holding register and shift register live in `sum_uart_tx`.

## Test plan
All scenarios use `CLK_DIV` = 4.
- **Single frame.** Send 0xA5 with `PARITY_EN` = 0.
  - `tx` shows 0, then 1,0,1,0,0,1,0,1, then 1, each for 4 cycles: 40 cycles total.
  - `busy` falls on the cycle after the stop bit ends.
- **Back-to-back.** Send 0x00, then 0xFF while the first frame is in flight.
  - The second byte is accepted one cycle after the first is loaded.
  - The second start bit follows the first stop bit with no gap: 80 cycles total.
  - A third `in_valid` is held off (`in_ready` = 0) until the 0xFF byte is loaded.
- **Parity.** With `PARITY_EN` = 1, send 0x07. The parity bit is 1, and the frame is 44 cycles.
- **Parity, zero result.** With `PARITY_EN` = 1, send 0x03. The parity bit is 0.
- **Reset mid-frame.** Assert `rst` during data bit 3 of 0x5A, with 0x11 buffered.
  - `tx` = 1 and `busy` = 0 on the next edge.
  - 0x11 is never transmitted.
  - `in_ready` rises on the first cycle after `rst` is released.
- **Producer stall.** Hold `in_valid` high with a fixed `in_data` for 3 frames. Exactly one frame is emitted per handshake, with no duplicates.
